invol_arbiter: RTL
==================

INVOL_ARBITER -- requirements
Module: invol_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of involuntary-response requesters (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 4096, SHALL set the maximum number of cycles a requester may own the channel after its grant.
REQ-003 Parameter RSP_ABORT, default 15, SHALL set the response code emitted when an owner times out.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low; the ports SHALL be named clk and rst_n.
REQ-005 Port clk, input, 1 bit: the system clock.
REQ-006 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 Port req, input, NREQ bits: per-requester involuntary request, held high until granted.
REQ-008 Port grant, output, NREQ bits: per-requester one-cycle grant pulse.
REQ-009 Port in_param_data, input, NREQ*32 bits: per-requester parameter word, slice i = bits [32*i+31:32*i].
REQ-010 Port in_param_write, input, NREQ bits: per-requester parameter write strobe.
REQ-011 Port in_done, input, NREQ bits: per-requester end-of-response pulse, with the response code on in_param_data.
REQ-012 Port up_req, output, 1 bit: request to the upstream response framer.
REQ-013 Port up_grant, input, 1 bit: upstream grant pulse.
REQ-014 Ports out_param_data (output, 32 bits), out_param_write (output, 1 bit) and out_done (output, 1 bit): the forwarded response stream.
REQ-015 Port owner, output, 3 bits: index of the current or last owner.
REQ-016 Port abort_flags, output, NREQ bits: sticky per-requester timeout flags.

Function
REQ-017 The arbiter SHALL be a four-state FSM: IDLE, WAIT_UP, OWN and ABORT.
REQ-018 IDLE with req nonzero: owner SHALL be latched by round-robin pick, searching from (last_owner+1) mod NREQ upward; up_req SHALL be set to 1; next state WAIT_UP.
REQ-019 WAIT_UP with up_grant=1: up_req SHALL be set to 0, grant[owner] SHALL pulse for exactly one cycle, the timeout counter SHALL load TIMEOUT_CYCLES, and next state OWN.
REQ-020 In WAIT_UP, changes on req SHALL be ignored; the owner stays latched even if its req drops.
REQ-021 In OWN, registered forwarding with 1-cycle latency SHALL apply: out_param_data <= slice[owner], out_param_write <= in_param_write[owner], out_done <= in_done[owner].
REQ-022 In OWN, slices, strobes and done pulses from non-owners SHALL be ignored.
REQ-023 OWN with in_done[owner]=1: last_owner SHALL be set to owner and next state IDLE; the next arbitration occurs in IDLE, giving a 1-cycle minimum gap between grants.
REQ-024 OWN with the counter reaching 0 and no done pulse: next state ABORT.
REQ-025 If done and timeout occur in the same cycle, done SHALL win and no abort is raised.
REQ-026 ABORT SHALL last 1 cycle: out_param_write <= 0, out_done <= 1, out_param_data <= RSP_ABORT, abort_flags[owner] <= 1, last_owner <= owner, next state IDLE.
REQ-027 abort_flags SHALL clear only on reset.
REQ-028 When not forwarding, out_param_write and out_done SHALL be 0 and out_param_data SHALL hold its last value.
REQ-029 grant SHALL never have more than one bit set, and SHALL only be set in the cycle after up_grant is sampled in WAIT_UP.
REQ-030 up_grant outside WAIT_UP SHALL be ignored.
REQ-031 The counter width SHALL be $clog2(TIMEOUT_CYCLES+1); the round-robin index SHALL wrap from NREQ-1 to 0.

Reset
REQ-032 While rst_n=0: state IDLE; up_req, grant, out_param_write, out_done, out_param_data, abort_flags, owner and counter all 0; last_owner = NREQ-1, so the first pick searches from index 0.
REQ-033 Reset asserted mid-OWN or mid-WAIT_UP SHALL abandon the transaction with no out_done or abort emitted.

Verification
REQ-034 Single requester: req=0001, up_grant 3 cycles later -> grant=0001 for one cycle; the requester's writes A,B,C then done with code 3 -> out_param_write high for A,B,C and out_done with data 3, each 1 cycle later.
REQ-035 Fairness: req=1111 held, each owner completes immediately -> grant order 0,1,2,3,0, with 1 idle cycle between each done and the next up_req.
REQ-036 Timeout: TIMEOUT_CYCLES=16, owner 2 never pulses done -> out_done with data 15 arrives 17 cycles after grant; abort_flags=0100; the next pick starts at 3.
REQ-037 Collision: done and counter expiry in the same cycle -> normal done is forwarded and abort_flags stays 0.
REQ-038 Isolation: a non-owner pulses in_done and in_param_write during OWN -> no output activity.
REQ-039 Reset: rst_n pulsed low during OWN -> all outputs 0 immediately; after release, req=0010 -> owner 1 granted.

Source files
------------

// File: rtl/invol_arbiter.sv
// Round-robin arbiter granting one involuntary-response requester at a time access to an
// upstream response framer, forwarding its stream and aborting owners that overstay.
module invol_arbiter #(
  parameter int NREQ           = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int RSP_ABORT      = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  output logic [NREQ-1:0]      grant,
  input  logic [NREQ*32-1:0]   in_param_data,
  input  logic [NREQ-1:0]      in_param_write,
  input  logic [NREQ-1:0]      in_done,
  output logic                 up_req,
  input  logic                 up_grant,
  output logic [31:0]          out_param_data,
  output logic                 out_param_write,
  output logic                 out_done,
  output logic [2:0]           owner,
  output logic [NREQ-1:0]      abort_flags
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_UP, S_OWN, S_ABORT} state_t;

  state_t          r_state,       w_stateNext;
  logic [2:0]      r_owner,       w_ownerNext;
  logic [2:0]      r_lastOwner,   w_lastOwnerNext;
  logic            r_upReq,       w_upReqNext;
  logic [NREQ-1:0] r_grant,       w_grantNext;
  logic [CW-1:0]   r_cnt,         w_cntNext;
  logic [31:0]     r_outData,     w_outDataNext;
  logic            r_outWrite,    w_outWriteNext;
  logic            r_outDone,     w_outDoneNext;
  logic [NREQ-1:0] r_abortFlags,  w_abortFlagsNext;

  logic [2:0]      w_pick;
  logic [31:0]     w_ownData;
  logic            w_ownWrite;
  logic            w_ownDone;
  logic [NREQ-1:0] w_ownerOneHot;

  // Select the current owner's slice, strobe and done bit.
  always_comb begin
    w_ownData     = '0;
    w_ownWrite    = 1'b0;
    w_ownDone     = 1'b0;
    w_ownerOneHot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_owner == 3'(i)) begin
        w_ownData        = in_param_data[32*i +: 32];
        w_ownWrite       = in_param_write[i];
        w_ownDone        = in_done[i];
        w_ownerOneHot[i] = 1'b1;
      end
    end
  end

  // Round-robin pick: smallest offset after the last owner wins, so it is assigned last.
  always_comb begin
    w_pick = '0;
    for (int k = NREQ; k >= 1; k--) begin
      for (int i = 0; i < NREQ; i++) begin
        if (((int'(r_lastOwner) + k) % NREQ) == i && req[i]) begin
          w_pick = 3'(i);
        end
      end
    end
  end

  always_comb begin
    w_stateNext      = r_state;
    w_ownerNext      = r_owner;
    w_lastOwnerNext  = r_lastOwner;
    w_upReqNext      = r_upReq;
    w_grantNext      = '0;
    w_cntNext        = r_cnt;
    w_outDataNext    = r_outData;
    w_outWriteNext   = 1'b0;
    w_outDoneNext    = 1'b0;
    w_abortFlagsNext = r_abortFlags;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_ownerNext = w_pick;
          w_upReqNext = 1'b1;
          w_stateNext = S_WAIT_UP;
        end
      end
      S_WAIT_UP: begin
        if (up_grant) begin
          w_upReqNext = 1'b0;
          w_grantNext = w_ownerOneHot;
          w_cntNext   = CW'(TIMEOUT_CYCLES);
          w_stateNext = S_OWN;
        end
      end
      S_OWN: begin
        w_outDataNext  = w_ownData;
        w_outWriteNext = w_ownWrite;
        w_outDoneNext  = w_ownDone;
        // Done takes priority over expiry landing in the same cycle.
        if (w_ownDone) begin
          w_lastOwnerNext = r_owner;
          w_stateNext     = S_IDLE;
        end else if (r_cnt <= CW'(1)) begin
          w_cntNext   = '0;
          w_stateNext = S_ABORT;
        end else begin
          w_cntNext = r_cnt - CW'(1);
        end
      end
      S_ABORT: begin
        w_outDoneNext    = 1'b1;
        w_outDataNext    = 32'(RSP_ABORT);
        w_abortFlagsNext = r_abortFlags | w_ownerOneHot;
        w_lastOwnerNext  = r_owner;
        w_stateNext      = S_IDLE;
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_owner      <= '0;
      r_lastOwner  <= 3'(NREQ - 1);
      r_upReq      <= 1'b0;
      r_grant      <= '0;
      r_cnt        <= '0;
      r_outData    <= '0;
      r_outWrite   <= 1'b0;
      r_outDone    <= 1'b0;
      r_abortFlags <= '0;
    end else begin
      r_state      <= w_stateNext;
      r_owner      <= w_ownerNext;
      r_lastOwner  <= w_lastOwnerNext;
      r_upReq      <= w_upReqNext;
      r_grant      <= w_grantNext;
      r_cnt        <= w_cntNext;
      r_outData    <= w_outDataNext;
      r_outWrite   <= w_outWriteNext;
      r_outDone    <= w_outDoneNext;
      r_abortFlags <= w_abortFlagsNext;
    end
  end

  assign grant           = r_grant;
  assign up_req          = r_upReq;
  assign out_param_data  = r_outData;
  assign out_param_write = r_outWrite;
  assign out_done        = r_outDone;
  assign owner           = r_owner;
  assign abort_flags     = r_abortFlags;

endmodule
